output_port: RTL and testbench
==============================

OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of in_addr.
REQ-002 Parameter DATA_WIDTH, default 32, width of data path.
REQ-003 Parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-004 Parameter PORT_ID, default 0, this port's index 0..3 in the 1x4 router.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 in_addr  input  ADDR_WIDTH  destination address of offered word.
REQ-008 in_data  input  DATA_WIDTH  offered word from input side.
REQ-009 in_valid  input  1  offered word valid.
REQ-010 in_ready  output  1  port can accept a word this cycle.
REQ-011 out_data  output  DATA_WIDTH  head-of-queue word to downstream.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  words currently stored.

Function
REQ-015 Address match: in_addr[1:0] == PORT_ID[1:0]; upper address bits ignored.
REQ-016 Push: in_valid && in_ready && match; word stored at tail on that edge.
REQ-017 Valid word with mismatched address: ignored, no state change, no error.
REQ-018 in_ready = !full, combinational from registered count only; never depends on out_ready or in_valid.
REQ-019 Pop: out_valid && out_ready; head advances on that edge.
REQ-020 out_valid = (fifo_count != 0); out_data = head entry, first-word-fall-through, from registers.
REQ-021 Latency: word pushed at edge N is visible on out_data/out_valid after edge N when FIFO was empty (1 cycle).
REQ-022 Order preserved; no word lost or duplicated.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-024 Full (count == DEPTH): in_ready low; pop in same cycle does not enable push that cycle.
REQ-025 Empty: out_valid low, out_ready ignored, out_data holds last value (don't-care).
REQ-026 Read/write pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-027 out_data stable while out_valid && !out_ready.

Reset
REQ-028 reset low at an edge: pointers 0, fifo_count 0, out_valid 0, in_ready 1 after edge.
REQ-029 Reset mid-operation flushes all stored words; push/pop on reset edge discarded.
REQ-030 Storage array not reset; out_data value undefined until first push.

Configuration
REQ-031 Macro OUTPUT_PORT_STATS_EN defined: adds output pkt_count 32 bits, counts pops, wraps 0xFFFFFFFF->0, cleared by reset.
REQ-032 Macro undefined: pkt_count port and counter absent; behaviour otherwise identical.

Structure
REQ-033 Package router_pkg: ADDR_WIDTH/DATA_WIDTH defaults, NUM_PORTS = 4, PORT_SEL_WIDTH = 2 constants.
REQ-034 One sub-module sync_fifo (DEPTH x DATA_WIDTH, push/pop/full/empty/count); output_port holds address match, handshake glue, stats counter.

Verification
REQ-035 PORT_ID=2; in_addr=0x12, in_data=0xA5A5A5A5, one cycle valid, out_ready=1 -> out_valid high next cycle with 0xA5A5A5A5, one pop, count back to 0.
REQ-036 PORT_ID=2; in_addr=0x11 valid 3 cycles -> no push, fifo_count stays 0, out_valid stays 0.
REQ-037 DEPTH=4, out_ready=0, push 1,2,3,4,5 -> in_ready low after 4th, 5th not stored; then out_ready=1 -> 1,2,3,4 in order.
REQ-038 Count=2, push and pop same cycle -> count stays 2, order kept.
REQ-039 Count=3, reset low one cycle -> count 0, out_valid 0, in_ready 1; prior words never emerge.
REQ-040 OUTPUT_PORT_STATS_EN defined, 10 pops -> pkt_count = 10; preload counter near wrap, 2 pops past 0xFFFFFFFF -> 1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x4 router output ports.
package router_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int NUM_PORTS      = 4;
  localparam int PORT_SEL_WIDTH = 2;

  // Only the low select bits route a word; upper address bits are ignored.
  function automatic logic port_match(input logic [PORT_SEL_WIDTH-1:0] sel,
                                      input int port_id);
    return sel == port_id[PORT_SEL_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; read data comes straight from storage registers.
module sync_fifo
  import router_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;

  // Callers gate push with !full and pop with !empty; the guards here keep the FIFO safe anyway.
  logic do_push;
  logic do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/output_port.sv
// One output port of the 1x4 router: address match, FIFO handshake glue, optional pop counter.
// Optional feature: define OUTPUT_PORT_STATS_EN to add the pkt_count output.
module output_port
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PORT_ID    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef OUTPUT_PORT_STATS_EN
  output logic [31:0]             pkt_count,
`endif
  output logic [$clog2(DEPTH):0]  fifo_count
);

  logic full;
  logic empty;
  logic match;
  logic push;
  logic pop;
  logic addr_hi_unused;

  assign match          = port_match(in_addr[PORT_SEL_WIDTH-1:0], PORT_ID);
  assign addr_hi_unused = ^in_addr[ADDR_WIDTH-1:PORT_SEL_WIDTH];

  // in_ready comes from the registered count alone, so a same-cycle pop never frees a slot.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && match;
  assign pop       = out_valid && out_ready;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

`ifdef OUTPUT_PORT_STATS_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge clk) begin
    if (!reset)   pkt_count_q <= '0;
    else if (pop) pkt_count_q <= pkt_count_q + 32'd1;
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_output_port.sv
// Directed scoreboard bench for output_port (PORT_ID=2, DEPTH=4).
module tb_output_port;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PID   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fifo_count;
`ifdef OUTPUT_PORT_STATS_EN
  logic [31:0]   pkt_count;
`endif

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  int pops   = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  output_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .PORT_ID(PID)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef OUTPUT_PORT_STATS_EN
    .pkt_count  (pkt_count),
`endif
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check pop data and in_ready before the edge, state after it.
  task automatic step(input string tag, input logic rst_b, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic v, input logic ordy);
    logic acc;
    logic pp;
    logic [DW-1:0] head;
    @(negedge clk);
    reset = rst_b; in_addr = a; in_data = d; in_valid = v; out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(mcount < DEPTH));
    acc = v && (mcount < DEPTH) && (a[1:0] == 2'(PID));
    pp  = ordy && (mcount > 0);
    if (mcount > 0) begin
      head = sb[0];
      chk({tag, ".out_data"}, 64'(out_data), 64'(head));
    end
    if (!rst_b) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (pp) begin
        void'(sb.pop_front());
        pops++;
      end
      if (acc) sb.push_back(d);
      mcount = sb.size();
    end
    @(posedge clk);
    #1;
    chk({tag, ".count"}, 64'(fifo_count), 64'(mcount));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mcount != 0));
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b1, '0, '0, 1'b0, ordy);
  endtask

  task automatic put(input string tag, input logic [DW-1:0] d, input logic ordy);
    step(tag, 1'b1, 32'h2, d, 1'b1, ordy);
  endtask

  initial begin
    reset = 1'b0; in_addr = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 64'(fifo_count), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    // Single word through, one-cycle latency
    step("single", 1'b1, 32'h12, 32'hA5A5_A5A5, 1'b1, 1'b1);
    chk("single.data", 64'(out_data), 64'hA5A5_A5A5);
    idle("single_pop", 1'b1);

    // Mismatched address never pushes
    for (int i = 0; i < 3; i++) step("mismatch", 1'b1, 32'h11, 32'hDEAD_0000 + i, 1'b1, 1'b1);

    // Upper address bits ignored
    step("hi_addr", 1'b1, 32'hFFFF_FFF2, 32'h0000_BEEF, 1'b1, 1'b0);
    idle("hi_addr_hold", 1'b0);
    idle("hi_addr_pop", 1'b1);

    // Fill to full with back-pressure, fifth word dropped, then drain in order
    for (int i = 1; i <= 5; i++) put("fill", DW'(i), 1'b0);
    chk("fill.in_ready_low", 64'(in_ready), 64'd0);
    // Full with a pop in the same cycle: push still refused
    put("full_pop", 32'h99, 1'b1);
    for (int i = 0; i < 4; i++) idle("drain", 1'b1);

    // Count 2, simultaneous push and pop keeps count and order
    put("pp_a", 32'h10, 1'b0);
    put("pp_b", 32'h11, 1'b0);
    put("pp_both", 32'h12, 1'b1);
    chk("pp_both.count2", 64'(fifo_count), 64'd2);
    for (int i = 0; i < 3; i++) idle("pp_drain", 1'b1);

    // Reset mid-operation flushes stored words and discards the edge's push
    put("flush_a", 32'h20, 1'b0);
    put("flush_b", 32'h21, 1'b0);
    put("flush_c", 32'h22, 1'b0);
    step("flush_rst", 1'b0, 32'h2, 32'h23, 1'b1, 1'b1);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    put("after_rst", 32'h30, 1'b0);
    chk("after_rst.data", 64'(out_data), 64'h30);
    idle("after_rst_pop", 1'b1);
    idle("after_rst_empty", 1'b1);

    // Random traffic, scoreboard-checked
    for (int i = 0; i < 40; i++)
      step("rand", 1'b1, 32'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom));
    for (int i = 0; i < DEPTH; i++) idle("rand_drain", 1'b1);

`ifdef OUTPUT_PORT_STATS_EN
    step("stats_rst", 1'b0, '0, '0, 1'b0, 1'b0);
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      put("stats_push", DW'(i), 1'b0);
      idle("stats_pop", 1'b1);
    end
    chk("stats.ten", 64'(pkt_count), 64'(pops));
    chk("stats.ten_const", 64'(pkt_count), 64'd10);
    @(negedge clk);
    dut.pkt_count_q = 32'hFFFF_FFFF;
    put("wrap_a", 32'h1, 1'b0);
    put("wrap_b", 32'h2, 1'b0);
    idle("wrap_pop1", 1'b1);
    idle("wrap_pop2", 1'b1);
    chk("stats.wrap", 64'(pkt_count), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
